// File: rtl/uart_rx_os16.sv
// 16x-oversampling 8N1 UART receiver with start validation, 3-sample majority vote and framing check.
// Define UART_RX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_rx_os16 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_end,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx_os16: CLK_FREQ/(BAUD*16) must be >= 1");
    end
  endgenerate

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif

  logic          rx_m, rxs;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [3:0]    s;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          v7, v8, v9, v_last, vote;
  logic [2:0]    state, state_n;
  logic          end_n, ferr_n;
  logic          bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  assign tick    = (cnt == CW'(DIV - 1));
  assign bit_end = tick && (s == 4'd15);
  // Stop decides at s==9, before v9 is registered, so the live sample stands in.
  assign v_last  = (s == 4'd9) ? rxs : v9;
  assign vote    = (v7 & v8) | (v7 & v_last) | (v8 & v_last);

`ifdef UART_RX_PARITY_EN
  logic par_bit, perr_n, par_ok;
  assign par_ok = ~(^shift ^ par_bit);
`endif

  always_comb begin
    state_n = state;
    end_n   = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE:      if (!rxs) state_n = START;
      START:     if (bit_end) state_n = vote ? IDLE : DATA;
      DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (bit_end) state_n = STOP;
`endif
      STOP: begin
        if (tick && s == 4'd9) begin
          if (vote) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            end_n  = par_ok;
            perr_n = ~par_ok;
`else
            end_n  = 1'b1;
`endif
          end else begin
            state_n = WAIT_HIGH;
            ferr_n  = 1'b1;
          end
        end
      end
      WAIT_HIGH: if (rxs) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      s            <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      v7           <= 1'b0;
      v8           <= 1'b0;
      v9           <= 1'b0;
      rx_data      <= '0;
      rx_end       <= 1'b0;
      rx_busy      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_n;
      rx_busy      <= (state_n != IDLE);
      rx_end       <= end_n;
      rx_frame_err <= ferr_n;
      if (end_n) rx_data <= shift;

      if (state == IDLE && !rxs) begin
        cnt <= '0;
        s   <= '0;
      end else begin
        cnt <= tick ? '0 : CW'(cnt + 1'b1);
        if (tick && state != IDLE) s <= s + 4'd1;
      end

      if (tick) begin
        if (s == 4'd7) v7 <= rxs;
        if (s == 4'd8) v8 <= rxs;
        if (s == 4'd9) v9 <= rxs;
      end

      if (state == START && bit_end) bit_idx <= '0;
      if (state == DATA && bit_end) begin
        shift[bit_idx] <= vote;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_parity_err <= perr_n;
      if (state == PARITY && bit_end) par_bit <= vote;
    end
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed, table-driven bench for uart_rx_os16 at 16 clk per bit (DIV=1).
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_end, rx_busy, rx_frame_err, rx_parity_err;

  uart_rx_os16 #(.CLK_FREQ(16_000_000), .BAUD(1_000_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_end(rx_end),
    .rx_busy(rx_busy), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_CLK = 176;
`else
  localparam int FRAME_CLK = 160;
`endif
  // Start edge -> rx_end: 2 sync + 1 detect + bits up to mid-stop.
  localparam int LAT = FRAME_CLK - 3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int end_cnt = 0, ferr_cnt = 0, perr_cnt = 0, both_cnt = 0;
  int last_end_cyc = 0, prev_end_cyc = 0;
  logic [7:0] last_data = '0, prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_end) begin
      end_cnt      = end_cnt + 1;
      prev_end_cyc = last_end_cyc;
      last_end_cyc = cyc;
      prev_data    = last_data;
      last_data    = rx_data;
    end
    if (rx_frame_err)  ferr_cnt = ferr_cnt + 1;
    if (rx_parity_err) perr_cnt = perr_cnt + 1;
    if (rx_end && rx_frame_err) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] d, input logic pb, input logic sb);
    start_cyc = cyc;
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = pb;
    idle(16);
`endif
    rx = sb;
    idle(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic sb);
    send_raw(d, ^d, sb);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         exp_end;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt[6];
  int e0, f0, p0;
  logic [7:0] cur_data;

  initial begin
    vt[0] = '{8'hA5, 1'b1, 0,   1, 0, 8'hA5};
    vt[1] = '{8'h3C, 1'b0, 100, 0, 1, 8'hA5};
    vt[2] = '{8'h5A, 1'b1, 0,   1, 0, 8'h5A};
    vt[3] = '{8'hC3, 1'b0, 0,   0, 1, 8'h5A};
    vt[4] = '{8'h81, 1'b1, 0,   1, 0, 8'h81};
    vt[5] = '{8'hFF, 1'b1, 0,   1, 0, 8'hFF};

    rst = 1'b1;
    rx  = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(50);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_end", rx_end, 0);
    chk("reset_rx_busy", rx_busy, 0);
    chk("reset_frame_err", rx_frame_err, 0);
    chk("reset_parity_err", rx_parity_err, 0);

    for (int v = 0; v < 6; v++) begin
      e0 = end_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(vt[v].data, vt[v].stop);
      if (vt[v].hold > 0) begin
        rx = 1'b0;
        idle(vt[v].hold / 2);
        chk("hold_busy", rx_busy, 1);
        idle(vt[v].hold - vt[v].hold / 2);
        rx = 1'b1;
        idle(6);
        chk("hold_release_busy", rx_busy, 0);
      end
      rx = 1'b1;
      idle(20);
      chk("vec_end_pulses", end_cnt - e0, vt[v].exp_end);
      chk("vec_ferr_pulses", ferr_cnt - f0, vt[v].exp_ferr);
      chk("vec_perr_pulses", perr_cnt - p0, 0);
      chk("vec_rx_data", rx_data, vt[v].exp_data);
      if (vt[v].exp_end == 1)
        chk("vec_latency_ok", int'((last_end_cyc - start_cyc) >= LAT - 4 &&
                                   (last_end_cyc - start_cyc) <= LAT + 3), 1);
    end
    cur_data = rx_data;

    // Start-bit glitch: short low pulse must be rejected silently.
    e0 = end_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(4);
    chk("glitch_busy_rise", rx_busy, 1);
    idle(26);
    chk("glitch_busy_fall", rx_busy, 0);
    chk("glitch_no_end", end_cnt - e0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    chk("glitch_data_held", rx_data, cur_data);

    // Back-to-back frames with no idle bits.
    e0 = end_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    chk("b2b_end_pulses", end_cnt - e0, 2);
    chk("b2b_spacing", last_end_cyc - prev_end_cyc, FRAME_CLK);
    chk("b2b_first_data", prev_data, 8'h00);
    chk("b2b_second_data", last_data, 8'hFF);

    // Reset in the middle of 0x81 after four data bits.
    e0 = end_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    rx = 1'b0;
    idle(16);
    rx = 1'b1; idle(16);
    rx = 1'b0; idle(48);
    rst = 1'b1;
    #1;
    chk("midrst_busy", rx_busy, 0);
    chk("midrst_data_cleared", rx_data, 0);
    idle(3);
    rx  = 1'b1;
    rst = 1'b0;
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(20);
    chk("midrst_end_pulses", end_cnt - e0, 1);
    chk("midrst_ferr_pulses", ferr_cnt - f0, 0);
    chk("midrst_perr_pulses", perr_cnt - p0, 0);
    chk("midrst_rx_data", rx_data, 8'h5A);

`ifdef UART_RX_PARITY_EN
    e0 = end_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_raw(8'h01, 1'b0, 1'b1);
    idle(20);
    chk("par_bad_perr", perr_cnt - p0, 1);
    chk("par_bad_no_end", end_cnt - e0, 0);
    chk("par_bad_data_held", rx_data, 8'h5A);
    e0 = end_cnt; p0 = perr_cnt;
    send_raw(8'h01, 1'b1, 1'b1);
    idle(20);
    chk("par_good_end", end_cnt - e0, 1);
    chk("par_good_no_perr", perr_cnt - p0, 0);
    chk("par_good_data", rx_data, 8'h01);
    p0 = perr_cnt; f0 = ferr_cnt;
    send_raw(8'h01, 1'b0, 1'b0);
    idle(20);
    chk("par_and_stop_bad_ferr", ferr_cnt - f0, 1);
    chk("par_and_stop_bad_no_perr", perr_cnt - p0, 0);
`else
    chk("no_parity_pulses_ever", perr_cnt, 0);
`endif

    chk("end_and_ferr_never_together", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
